// File: rtl/kul8_approx_mult.sv
`default_nettype none
// ============================================================================
//  Module   : kul8_approx_mult
//  Brief    : Registered 8x8 unsigned approximate multiplier (Kulkarni scheme).
//             Sixteen approximate 2x2 blocks (3x3 -> 7) are combined with
//             exact shift-and-add into 4x4 and then 8x8 partial products.
//             Latency is one cycle, fully pipelined, no backpressure.
//  Options  : define KUL8_ERR_DIST_EN to add the registered err_dist output
//             (exact product minus approximate product).
//  Revision : 1.0 - initial release
// ============================================================================
module kul8_approx_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] Y
`ifdef KUL8_ERR_DIST_EN
    ,
    output logic [15:0] err_dist
`endif
);

    // ------------------------------------------------------------------------
    // Level 1: sixteen 2x2 blocks. Index [i][j] multiplies a[2i+1:2i] by
    // b[2j+1:2j]. The middle bit uses OR instead of an adder; the two terms
    // collide only for 3x3, which is where the 9 -> 7 approximation comes from.
    // ------------------------------------------------------------------------
    logic [2:0] w_p2 [0:3][0:3];

    for (genvar gi = 0; gi < 4; gi++) begin : g_p2_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_p2_col
            logic [1:0] w_x;
            logic [1:0] w_y2;
            assign w_x  = a[2*gi+1 : 2*gi];
            assign w_y2 = b[2*gj+1 : 2*gj];
            assign w_p2[gi][gj] = {
                w_x[1] & w_y2[1],
                (w_x[1] & w_y2[0]) | (w_x[0] & w_y2[1]),
                w_x[0] & w_y2[0]
            };
        end
    end

    // ------------------------------------------------------------------------
    // Level 2: four 4x4 products. Index [n][m] multiplies nibble n of a by
    // nibble m of b, built exactly from the four 2x2 blocks underneath it.
    // Maximum value is 7 + 14*4 + 7*16 = 175, so 8 bits never overflow.
    // ------------------------------------------------------------------------
    logic [7:0] w_p4 [0:1][0:1];

    for (genvar gn = 0; gn < 2; gn++) begin : g_p4_row
        for (genvar gm = 0; gm < 2; gm++) begin : g_p4_col
            logic [7:0] w_ll;
            logic [7:0] w_hl;
            logic [7:0] w_lh;
            logic [7:0] w_hh;
            assign w_ll = {5'b0, w_p2[2*gn  ][2*gm  ]};
            assign w_hl = {5'b0, w_p2[2*gn+1][2*gm  ]};
            assign w_lh = {5'b0, w_p2[2*gn  ][2*gm+1]};
            assign w_hh = {5'b0, w_p2[2*gn+1][2*gm+1]};
            assign w_p4[gn][gm] = w_ll + ((w_hl + w_lh) << 2) + (w_hh << 4);
        end
    end

    // ------------------------------------------------------------------------
    // Level 3: 8x8 product from the four 4x4 products, exact shift-and-add.
    // Worst case 175 + 350*16 + 175*256 = 50575 fits in 16 bits.
    // ------------------------------------------------------------------------
    logic [15:0] w_ll8;
    logic [15:0] w_hl8;
    logic [15:0] w_lh8;
    logic [15:0] w_hh8;
    logic [15:0] w_approx;

    assign w_ll8    = {8'b0, w_p4[0][0]};
    assign w_hl8    = {8'b0, w_p4[1][0]};
    assign w_lh8    = {8'b0, w_p4[0][1]};
    assign w_hh8    = {8'b0, w_p4[1][1]};
    assign w_approx = w_ll8 + ((w_hl8 + w_lh8) << 4) + (w_hh8 << 8);

    // Output register: capture on in_valid, hold Y otherwise, async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Y         <= 16'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y <= w_approx;
            end
        end
    end

`ifdef KUL8_ERR_DIST_EN
    // ------------------------------------------------------------------------
    // Error measurement: full exact multiplier alongside the approximate one.
    // The approximation never exceeds the exact product, so the difference
    // is always non-negative.
    // ------------------------------------------------------------------------
    logic [15:0] w_exact;

    assign w_exact = {8'b0, a} * {8'b0, b};

    // Error register shares Y's enable and reset so the two stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_dist <= 16'd0;
        end else if (in_valid) begin
            err_dist <= w_exact - w_approx;
        end
    end
`else
    // Without the error output no exact multiplier is built; Y and out_valid
    // are unaffected.
`endif

endmodule
`default_nettype wire

// File: tb/tb_kul8_approx_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kul8_approx_mult
//  Brief    : Self-checking bench for kul8_approx_mult against a recursive
//             arithmetic reference model. Define KUL8_ERR_DIST_EN to also
//             check err_dist.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kul8_approx_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic [15:0] Y;
`ifdef KUL8_ERR_DIST_EN
    logic [15:0] err_dist;
`endif

    int total;
    int bad;

    kul8_approx_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .Y         (Y)
`ifdef KUL8_ERR_DIST_EN
        ,
        .err_dist  (err_dist)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the recursion written as plain integer arithmetic.
    function automatic int ref2(input int x, input int y);
        return (x == 3 && y == 3) ? 7 : x * y;
    endfunction

    function automatic int ref4(input int x, input int y);
        return ref2(x % 4, y % 4)
             + (ref2(x / 4, y % 4) + ref2(x % 4, y / 4)) * 4
             + ref2(x / 4, y / 4) * 16;
    endfunction

    function automatic int ref8(input int x, input int y);
        return ref4(x % 16, y % 16)
             + (ref4(x / 16, y % 16) + ref4(x % 16, y / 16)) * 16
             + ref4(x / 16, y / 16) * 256;
    endfunction

    // Drive one cycle of stimulus at the falling edge; return 1ns after the
    // following rising edge, where outputs are sampled.
    task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic dv);
        @(negedge clk);
        a        = da;
        b        = db;
        in_valid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // State while reset is held from time zero.
        #2;
        total++;
        if (Y !== 16'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial: Y=%0d out_valid=%b, required Y=0 out_valid=0", Y, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        // Load a nonzero result, then clear it asynchronously mid-cycle.
        drive(8'd255, 8'd255, 1'b1);
        total++;
        if (Y !== 16'd50575 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_preload: Y=%0d out_valid=%b, required Y=50575 out_valid=1", Y, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (Y !== 16'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: Y=%0d out_valid=%b, required Y=0 out_valid=0", Y, out_valid);
        end
`ifdef KUL8_ERR_DIST_EN
        total++;
        if (err_dist !== 16'd0) begin
            bad++;
            $display("FAIL reset_err_dist: err_dist=%0d, required 0", err_dist);
        end
`endif
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'd7, 8'd9, 1'b0);
            total++;
            if (out_valid !== 1'b0 || Y !== 16'd0) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d Y=%0d out_valid=%b, required Y=0 out_valid=0", i, Y, out_valid);
            end
        end
    endtask

    task automatic test_fixed_cases();
        logic [7:0] ta [8] = '{8'd2, 8'd10, 8'd255, 8'd0,   8'd3, 8'd12, 8'd15, 8'd255};
        logic [7:0] tb [8] = '{8'd2, 8'd10, 8'd1,   8'd200, 8'd3, 8'd12, 8'd15, 8'd255};
        int         ty [8] = '{4, 100, 255, 0, 7, 112, 175, 50575};
        int         te [8] = '{0, 0, 0, 0, 2, 32, 50, 14450};
        for (int i = 0; i < 8; i++) begin
            // Idle cycle between cases so each result stands alone.
            drive(8'd0, 8'd0, 1'b0);
            drive(ta[i], tb[i], 1'b1);
            total++;
            if (Y !== 16'(ty[i]) || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL fixed_case a=%0d b=%0d: Y=%0d out_valid=%b, required Y=%0d out_valid=1",
                         ta[i], tb[i], Y, out_valid, ty[i]);
            end
`ifdef KUL8_ERR_DIST_EN
            total++;
            if (err_dist !== 16'(te[i])) begin
                bad++;
                $display("FAIL fixed_err_dist a=%0d b=%0d: err_dist=%0d, required %0d",
                         ta[i], tb[i], err_dist, te[i]);
            end
`else
            if (te[i] < 0) $display("unexpected negative table entry");
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [3] = '{8'd3, 8'd2, 8'd255};
        int         py [3] = '{7, 4, 50575};
        for (int i = 0; i < 3; i++) begin
            drive(pa[i], pa[i], 1'b1);
            total++;
            if (Y !== 16'(py[i]) || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL pipeline step %0d: Y=%0d out_valid=%b, required Y=%0d out_valid=1",
                         i, Y, out_valid, py[i]);
            end
        end
        // Operands changing between edges must not disturb the register.
        a = 8'd1;
        b = 8'd1;
        #2;
        total++;
        if (Y !== 16'd50575) begin
            bad++;
            $display("FAIL mid_cycle_change: Y=%0d, required 50575", Y);
        end
        drive(8'd17, 8'd33, 1'b0);
        total++;
        if (out_valid !== 1'b0 || Y !== 16'd50575) begin
            bad++;
            $display("FAIL pipeline_drop: Y=%0d out_valid=%b, required Y=50575 out_valid=0", Y, out_valid);
        end
    endtask

    task automatic test_random();
        int exp_y;
        exp_y = 50575;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rv;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            drive(ra, rb, rv);
            if (rv) exp_y = ref8(ra, rb);
            total++;
            if (Y !== 16'(exp_y) || out_valid !== rv) begin
                bad++;
                $display("FAIL random step %0d a=%0d b=%0d v=%b: Y=%0d out_valid=%b, required Y=%0d out_valid=%b",
                         i, ra, rb, rv, Y, out_valid, exp_y, rv);
            end
        end
    endtask

    task automatic test_exhaustive();
        int n_exact;
        int exp_y;
        int exact;
        n_exact = 0;
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                drive(8'(ia), 8'(ib), 1'b1);
                exp_y = ref8(ia, ib);
                exact = ia * ib;
                total++;
                if (Y !== 16'(exp_y) || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep a=%0d b=%0d: Y=%0d out_valid=%b, required Y=%0d out_valid=1",
                             ia, ib, Y, out_valid, exp_y);
                end
                total++;
                if (int'(Y) > exact) begin
                    bad++;
                    $display("FAIL sweep_bound a=%0d b=%0d: Y=%0d, required at most %0d", ia, ib, Y, exact);
                end
`ifdef KUL8_ERR_DIST_EN
                total++;
                if (err_dist !== 16'(exact - exp_y)) begin
                    bad++;
                    $display("FAIL sweep_err_dist a=%0d b=%0d: err_dist=%0d, required %0d",
                             ia, ib, err_dist, exact - exp_y);
                end
`endif
                if (int'(Y) == exact) n_exact++;
            end
        end
        $display("exhaustive sweep: exact pairs=%0d of 65536, accuracy=%0.2f%%",
                 n_exact, 100.0 * real'(n_exact) / 65536.0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        test_reset();
        test_fixed_cases();
        test_back_to_back();
        test_random();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
